// File: rtl/carfield_pkg.sv
// Shared types and defaults for the Carfield per-domain clock-divider controller.
package carfield_pkg;

  localparam int unsigned CarfieldNumDomains = 6;
  localparam int unsigned CarfieldDivWidth   = 8;

  typedef logic [CarfieldDivWidth-1:0] carfield_div_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_GATE   = 3'd2,
    ST_PROG   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } clkdiv_state_e;

  localparam carfield_div_t CarfieldDomainDefaultDiv = carfield_div_t'(1);
  localparam carfield_div_t [CarfieldNumDomains-1:0] CarfieldDefaultDiv =
    {CarfieldNumDomains{CarfieldDomainDefaultDiv}};

  // One counter serves every phase, so it is sized for the longest of them.
  function automatic int unsigned clkdiv_cnt_width(input int unsigned a,
                                                   input int unsigned b,
                                                   input int unsigned c);
    int unsigned m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/carfield_clkdiv_timer.sv
// Loadable down-counter that parks at zero; o_done is high while the count is zero.
module carfield_clkdiv_timer #(
  parameter int unsigned Width = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  output logic             o_done
);

  logic [Width-1:0] r_count;

  // Count register: load has priority, otherwise decrement until zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - {{(Width-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/carfield_domain_clkdiv_ctrl.sv
// Sequences software divider updates per clock domain: gate, program via
// valid/ready, settle, ungate, then report completion or error.
module carfield_domain_clkdiv_ctrl
  import carfield_pkg::*;
#(
  parameter int unsigned NumDomains    = CarfieldNumDomains,
  parameter int unsigned DivWidth      = CarfieldDivWidth,
  parameter logic [NumDomains-1:0][DivWidth-1:0] DefaultDiv = CarfieldDefaultDiv,
  parameter int unsigned GateCycles    = 4,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned TimeoutCycles = 64,
  localparam int unsigned DomW = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [DomW-1:0]                req_domain_i,
  input  logic [DivWidth-1:0]            req_div_i,
  output logic                           rsp_valid_o,
  output logic                           rsp_err_o,
  output logic                           busy_o,
  output logic [NumDomains-1:0]          clk_en_o,
  output logic [NumDomains*DivWidth-1:0] div_value_o,
  output logic [NumDomains-1:0]          div_valid_o,
  input  logic [NumDomains-1:0]          div_ready_i
);

  localparam int unsigned CntW = clkdiv_cnt_width(GateCycles, SettleCycles, TimeoutCycles);
  localparam logic [DomW:0] NumDomainsW = (DomW+1)'(NumDomains);

  clkdiv_state_e r_state, w_next_state;
  logic [DomW-1:0]                   r_dom;
  logic [DivWidth-1:0]               r_div, r_old_div;
  logic [NumDomains-1:0]             r_clk_en, r_div_valid;
  logic [NumDomains-1:0][DivWidth-1:0] r_div_value;
  logic r_req_ready, r_busy, r_rsp_valid, r_rsp_err;

  logic                w_dom_ok, w_dom_en, w_dom_ready;
  logic [DivWidth-1:0] w_cur_div;
  logic                w_latch_req, w_gate, w_program, w_accept, w_abort, w_ungate, w_rsp_err;
  logic                w_tmr_load, w_tmr_done;
  logic [CntW-1:0]     w_tmr_value;

  carfield_clkdiv_timer #(.Width(CntW)) u_timer (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  // Guarded views of the targeted domain; an out-of-range index never reaches the arrays.
  always_comb begin
    w_dom_ok    = ({1'b0, r_dom} < NumDomainsW);
    w_cur_div   = '0;
    w_dom_en    = 1'b1;
    w_dom_ready = 1'b0;
    if (w_dom_ok) begin
      w_cur_div   = r_div_value[r_dom];
      w_dom_en    = r_clk_en[r_dom];
      w_dom_ready = div_ready_i[r_dom];
    end else begin
      w_cur_div   = '0;
    end
  end

  // Next-state and per-cycle action strobes.
  always_comb begin
    w_next_state = r_state;
    w_latch_req  = 1'b0;
    w_gate       = 1'b0;
    w_program    = 1'b0;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    w_ungate     = 1'b0;
    w_rsp_err    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_latch_req  = 1'b1;
          w_next_state = ST_CHECK;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!w_dom_ok || (r_div == '0)) begin
          w_rsp_err    = 1'b1;
          w_next_state = ST_DONE;
        end else if (r_div == w_cur_div) begin
          w_next_state = ST_DONE;
        end else begin
          w_gate       = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_value  = CntW'(GateCycles - 1);
          w_next_state = ST_GATE;
        end
      end
      ST_GATE: begin
        if (w_tmr_done) begin
          w_program    = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_value  = CntW'(TimeoutCycles - 1);
          w_next_state = ST_PROG;
        end else begin
          w_next_state = ST_GATE;
        end
      end
      ST_PROG: begin
        if (w_dom_ready) begin
          w_accept     = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_value  = CntW'(SettleCycles - 1);
          w_next_state = ST_SETTLE;
        end else if (w_tmr_done) begin
          w_abort      = 1'b1;
          w_rsp_err    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_PROG;
        end
      end
      ST_SETTLE: begin
        // Ungate first, report one cycle later once the domain clock is running again.
        if (w_tmr_done && !w_dom_en) begin
          w_ungate     = 1'b1;
          w_next_state = ST_SETTLE;
        end else if (w_tmr_done) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, handshake and per-domain output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_dom       <= '0;
      r_div       <= '0;
      r_old_div   <= '0;
      r_clk_en    <= '1;
      r_div_valid <= '0;
      r_div_value <= DefaultDiv;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == ST_IDLE);
      r_busy      <= (w_next_state != ST_IDLE);
      r_rsp_valid <= (w_next_state == ST_DONE);
      r_rsp_err   <= (w_next_state == ST_DONE) && w_rsp_err;
      if (w_latch_req) begin
        r_dom <= req_domain_i;
        r_div <= req_div_i;
      end
      if (w_gate) begin
        r_clk_en[r_dom] <= 1'b0;
        r_old_div       <= w_cur_div;
      end
      if (w_program) begin
        r_div_value[r_dom] <= r_div;
        r_div_valid[r_dom] <= 1'b1;
      end
      if (w_accept) begin
        r_div_valid[r_dom] <= 1'b0;
      end
      if (w_abort) begin
        r_div_valid[r_dom] <= 1'b0;
        r_div_value[r_dom] <= r_old_div;
        r_clk_en[r_dom]    <= 1'b1;
      end
      if (w_ungate) begin
        r_clk_en[r_dom] <= 1'b1;
      end
    end
  end

  assign req_ready_o = r_req_ready;
  assign busy_o      = r_busy;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign clk_en_o    = r_clk_en;
  assign div_valid_o = r_div_valid;
  assign div_value_o = r_div_value;

endmodule

// File: tb/tb_carfield_domain_clkdiv_ctrl.sv
// Directed bench for carfield_domain_clkdiv_ctrl with hand-computed cycle latencies.
module tb_carfield_domain_clkdiv_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_domain;
  logic [7:0]  req_div;
  logic        rsp_valid, rsp_err, busy;
  logic [5:0]  clk_en, div_valid, div_ready;
  logic [47:0] div_value;

  int n_tests = 0;
  int n_fail  = 0;
  int t_fall, t_rise, t_vrise, t_vfall, t_rsp, t2;
  logic got_err, others_bad, ready_bad;

  carfield_domain_clkdiv_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_domain_i (req_domain),
    .req_div_i    (req_div),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .clk_en_o     (clk_en),
    .div_value_o  (div_value),
    .div_valid_o  (div_valid),
    .div_ready_i  (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request and record, in cycles after the accept cycle T, when each event happens.
  task automatic run_seq(input logic [2:0] dom, input logic [7:0] div, input logic hold);
    logic [5:0]  en0, dv0, m;
    logic [47:0] val0, vm;
    m  = (dom < 3'd6) ? (6'b000001 << dom) : 6'b000000;
    vm = (dom < 3'd6) ? (48'h0000_0000_00ff << {dom, 3'b000}) : 48'h0;
    t_fall = -1; t_rise = -1; t_vrise = -1; t_vfall = -1; t_rsp = -1;
    got_err = 1'b0; others_bad = 1'b0; ready_bad = 1'b0;
    @(negedge clk);
    en0 = clk_en; dv0 = div_valid; val0 = div_value;
    req_valid = 1'b1; req_domain = dom; req_div = div;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 200 && t_rsp < 0; k++) begin
      @(negedge clk);
      if (hold && k == 3) begin
        req_valid = 1'b1; req_domain = 3'd5; req_div = 8'd1;
      end
      if ((m & ~clk_en) != 6'd0 && t_fall < 0) t_fall = k;
      if ((m & clk_en) != 6'd0 && t_fall >= 0 && t_rise < 0) t_rise = k;
      if ((m & div_valid) != 6'd0 && t_vrise < 0) t_vrise = k;
      if ((m & div_valid) == 6'd0 && t_vrise >= 0 && t_vfall < 0) t_vfall = k;
      if (((clk_en ^ en0) & ~m) != 6'd0) others_bad = 1'b1;
      if (((div_valid ^ dv0) & ~m) != 6'd0) others_bad = 1'b1;
      if (((div_value ^ val0) & ~vm) != 48'h0) others_bad = 1'b1;
      if (req_ready) ready_bad = 1'b1;
      if (rsp_valid) begin
        t_rsp = k; got_err = rsp_err;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_domain = 3'd0; req_div = 8'd0; div_ready = 6'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_hold_clk_en", clk_en, 6'h3f);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_clk_en", clk_en, 6'h3f);
    check_eq("rst_div_value", div_value, 48'h01_01_01_01_01_01);
    check_eq("rst_div_valid", div_valid, 6'h00);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);

    // Domain 2 -> div 4, ready immediate.
    div_ready = 6'b000100;
    run_seq(3'd2, 8'd4, 1'b0);
    check_eq("d2_en_fall", t_fall, 2);
    check_eq("d2_valid_rise", t_vrise, 6);
    check_eq("d2_valid_fall", t_vfall, 7);
    check_eq("d2_en_rise", t_rise, 15);
    check_eq("d2_rsp_time", t_rsp, 16);
    check_eq("d2_rsp_err", got_err, 1'b0);
    check_eq("d2_div_value", div_value[23:16], 8'd4);
    check_eq("d2_others", others_bad, 1'b0);
    check_eq("d2_ready_busy", ready_bad, 1'b0);
    @(negedge clk);
    check_eq("d2_ready_after", req_ready, 1'b1);

    // Out-of-range domain and zero divider are rejected without side effects.
    run_seq(3'd7, 8'd5, 1'b0);
    check_eq("bad_dom_rsp_time", t_rsp, 2);
    check_eq("bad_dom_err", got_err, 1'b1);
    check_eq("bad_dom_others", others_bad, 1'b0);
    run_seq(3'd3, 8'd0, 1'b0);
    check_eq("div0_rsp_time", t_rsp, 2);
    check_eq("div0_err", got_err, 1'b1);
    check_eq("div0_no_gate", t_fall, -1);
    check_eq("div0_others", others_bad, 1'b0);

    // Same divider as current: no gating, success.
    run_seq(3'd1, 8'd1, 1'b0);
    check_eq("same_rsp_time", t_rsp, 2);
    check_eq("same_err", got_err, 1'b0);
    check_eq("same_no_gate", t_fall, -1);

    // Domain 0 never acknowledges; ready on other domains must be ignored.
    div_ready = 6'b111110;
    run_seq(3'd0, 8'd3, 1'b0);
    check_eq("to_en_fall", t_fall, 2);
    check_eq("to_valid_rise", t_vrise, 6);
    check_eq("to_valid_fall", t_vfall, 70);
    check_eq("to_en_rise", t_rise, 70);
    check_eq("to_rsp_time", t_rsp, 70);
    check_eq("to_err", got_err, 1'b1);
    check_eq("to_div_revert", div_value[7:0], 8'd1);
    check_eq("to_others", others_bad, 1'b0);

    // A second request held during a busy sequence waits until DONE+1.
    div_ready = 6'b111111;
    run_seq(3'd4, 8'd2, 1'b1);
    check_eq("hold_rsp_time", t_rsp, 16);
    check_eq("hold_ready_low", ready_bad, 1'b0);
    check_eq("hold_others", others_bad, 1'b0);
    @(negedge clk);
    check_eq("hold_ready_done1", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    t2 = -1;
    for (int k = 1; k <= 10 && t2 < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        t2 = k; got_err = rsp_err;
      end
    end
    check_eq("hold_second_rsp", t2, 2);
    check_eq("hold_second_err", got_err, 1'b0);
    check_eq("hold_d4_value", div_value[39:32], 8'd2);

    // Asynchronous reset in the middle of SETTLE for domain 3.
    @(negedge clk);
    req_valid = 1'b1; req_domain = 3'd3; req_div = 8'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("settle_en_low", clk_en[3], 1'b0);
    check_eq("settle_div_new", div_value[31:24], 8'd2);
    check_eq("settle_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_clk_en", clk_en, 6'h3f);
    check_eq("arst_div_value", div_value, 48'h01_01_01_01_01_01);
    check_eq("arst_div_valid", div_valid, 6'h00);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
